// File: rtl/mcp23s17_pkg.sv
// mcp23s17_pkg: MCP23S17 register map, opcode helper, SPI frame layout and scheduler FSM encoding
package mcp23s17_pkg;
    localparam logic [7:0] OPC_BASE   = 8'h40;
    localparam logic [7:0] REG_IODIRA = 8'h00;
    localparam logic [7:0] REG_IODIRB = 8'h01;
    localparam logic [7:0] REG_IOCON  = 8'h0A;
    localparam logic [7:0] REG_GPIOA  = 8'h12;
    localparam logic [7:0] REG_GPIOB  = 8'h13;
    localparam logic [7:0] REG_OLATA  = 8'h14;
    localparam logic [7:0] REG_OLATB  = 8'h15;
    localparam logic [7:0] IOCON_INIT = 8'h08;
    localparam logic [2:0] S_INIT_ISSUE = 3'd0;
    localparam logic [2:0] S_INIT_WAIT  = 3'd1;
    localparam logic [2:0] S_IDLE       = 3'd2;
    localparam logic [2:0] S_POLL_ISSUE = 3'd3;
    localparam logic [2:0] S_POLL_WAIT  = 3'd4;
    typedef struct packed {
        logic [7:0] op;
        logic [7:0] rg;
        logic [7:0] data;
    } frame_t;
    function automatic logic [7:0] opcode(input logic [2:0] addr, input logic rd);
        return OPC_BASE | {4'b0000, addr, rd};
    endfunction
endpackage

// File: rtl/tick_timer.sv
// tick_timer: free-running divider emitting a one-cycle tick every POLL_DIV clocks
module tick_timer #(
    parameter int POLL_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(POLL_DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == W'(POLL_DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mcp23s17_scheduler.sv
// mcp23s17_scheduler: configures two MCP23S17 expanders, then periodically writes LEDs and reads switches
module mcp23s17_scheduler
    import mcp23s17_pkg::*;
#(
    parameter int         POLL_DIV = 50000,
    parameter int         TIMEOUT  = 4096,
    parameter logic [2:0] OUT_ADDR = 3'd0,
    parameter logic [2:0] IN_ADDR  = 3'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] led,
    output logic        frm_start,
    output logic [23:0] frm_tx,
    input  logic        frm_done,
    input  logic [7:0]  frm_rx,
    output logic [15:0] sw,
    output logic        init_done,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic          tick, polling, waiting, expired;
    logic [2:0]    state_q, state_d, step_q, step_d;
    logic [15:0]   led_q, led_d, sw_q, sw_d;
    logic [7:0]    gpa_q, gpa_d;
    logic [TW-1:0] to_q, to_d;
    logic          start_q, start_d, init_done_q, init_done_d;
    logic          overrun_q, overrun_d, toerr_q, toerr_d;
    frame_t        tx_q, tx_d;

    tick_timer #(.POLL_DIV(POLL_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    function automatic frame_t rom(input logic poll, input logic [2:0] step, input logic [15:0] l);
        frame_t f;
        f = '0;
        if (poll)
            case (step)
                3'd0:    f = {opcode(OUT_ADDR, 1'b0), REG_OLATA, l[7:0]};
                3'd1:    f = {opcode(OUT_ADDR, 1'b0), REG_OLATB, l[15:8]};
                3'd2:    f = {opcode(IN_ADDR, 1'b1), REG_GPIOA, 8'h00};
                default: f = {opcode(IN_ADDR, 1'b1), REG_GPIOB, 8'h00};
            endcase
        else
            case (step)
                3'd0:    f = {opcode(3'd0, 1'b0), REG_IOCON, IOCON_INIT};
                3'd1:    f = {opcode(IN_ADDR, 1'b0), REG_IODIRA, 8'hFF};
                3'd2:    f = {opcode(IN_ADDR, 1'b0), REG_IODIRB, 8'hFF};
                3'd3:    f = {opcode(OUT_ADDR, 1'b0), REG_IODIRA, 8'h00};
                default: f = {opcode(OUT_ADDR, 1'b0), REG_IODIRB, 8'h00};
            endcase
        return f;
    endfunction

    assign polling = state_q == S_POLL_ISSUE || state_q == S_POLL_WAIT;
    assign waiting = state_q == S_INIT_WAIT || state_q == S_POLL_WAIT;
    // a frm_done arriving on the expiry cycle still completes the frame
    assign expired = waiting && !frm_done && to_q == TW'(TIMEOUT);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        led_d       = led_q;
        sw_d        = sw_q;
        gpa_d       = gpa_q;
        tx_d        = tx_q;
        start_d     = 1'b0;
        init_done_d = init_done_q;
        overrun_d   = overrun_q | (tick & polling);
        toerr_d     = toerr_q | expired;
        to_d        = waiting ? to_q + 1'b1 : to_q;
        case (state_q)
            S_INIT_ISSUE, S_POLL_ISSUE: begin
                start_d = 1'b1;
                tx_d    = rom(polling, step_q, led_q);
                to_d    = '0;
                state_d = polling ? S_POLL_WAIT : S_INIT_WAIT;
            end
            S_IDLE: if (tick && init_done_q) begin
                state_d = S_POLL_ISSUE;
                step_d  = '0;
                led_d   = led;
            end
            S_INIT_WAIT: if (frm_done) begin
                state_d     = step_q == 3'd4 ? S_IDLE : S_INIT_ISSUE;
                step_d      = step_q == 3'd4 ? 3'd0 : step_q + 3'd1;
                init_done_d = step_q == 3'd4;
            end
            S_POLL_WAIT: if (frm_done) begin
                gpa_d   = step_q == 3'd2 ? frm_rx : gpa_q;
                sw_d    = step_q == 3'd3 ? {frm_rx, gpa_q} : sw_q;
                state_d = step_q == 3'd3 ? S_IDLE : S_POLL_ISSUE;
                step_d  = step_q == 3'd3 ? 3'd0 : step_q + 3'd1;
            end
            default: begin
                state_d = S_INIT_ISSUE;
                step_d  = '0;
            end
        endcase
        if (expired) begin
            state_d     = S_INIT_ISSUE;
            step_d      = '0;
            init_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT_ISSUE;
            step_q      <= '0;
            led_q       <= '0;
            sw_q        <= '0;
            gpa_q       <= '0;
            tx_q        <= '0;
            start_q     <= 1'b0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            toerr_q     <= 1'b0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            led_q       <= led_d;
            sw_q        <= sw_d;
            gpa_q       <= gpa_d;
            tx_q        <= tx_d;
            start_q     <= start_d;
            init_done_q <= init_done_d;
            overrun_q   <= overrun_d;
            toerr_q     <= toerr_d;
            to_q        <= to_d;
        end
    end

    assign frm_start   = start_q;
    assign frm_tx      = tx_q;
    assign sw          = sw_q;
    assign init_done   = init_done_q;
    assign overrun     = overrun_q;
    assign timeout_err = toerr_q;
endmodule

// File: tb/tb_mcp23s17_scheduler.sv
// tb_mcp23s17_scheduler: frame-engine model plus scoreboard of expected SPI frames for two scheduler instances
module tb_mcp23s17_scheduler;
    typedef struct {
        logic [15:0] led;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] sw;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst[2];
    logic [15:0] led[2];
    logic        fs[2];
    logic [23:0] ftx[2];
    logic        fd[2];
    logic [7:0]  frx[2];
    logic [15:0] sw[2];
    logic        idn[2], ovr[2], toe[2];
    logic [7:0]  ra[2], rb[2];
    int          dly[2] = '{30, 40};
    bit          drop = 1'b0;
    logic [23:0] exp_q[$];
    int          checks = 0, errors = 0, nstart = 0;
    logic [23:0] hold = '0;
    bit          busy = 1'b0;
    vec_t        vt[3];
    logic [15:0] prev;
    int          n, n0;

    always #5 clk = ~clk;

    mcp23s17_scheduler #(.POLL_DIV(300)) u0 (
        .clk(clk), .rst(rst[0]), .led(led[0]), .frm_start(fs[0]), .frm_tx(ftx[0]),
        .frm_done(fd[0]), .frm_rx(frx[0]), .sw(sw[0]), .init_done(idn[0]),
        .overrun(ovr[0]), .timeout_err(toe[0]));

    mcp23s17_scheduler #(.POLL_DIV(100)) u1 (
        .clk(clk), .rst(rst[1]), .led(led[1]), .frm_start(fs[1]), .frm_tx(ftx[1]),
        .frm_done(fd[1]), .frm_rx(frx[1]), .sw(sw[1]), .init_done(idn[1]),
        .overrun(ovr[1]), .timeout_err(toe[1]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // frame engine: frm_done pulses dly cycles after frm_start; a dropped OLATB frame never completes
    initial begin
        int cnt[2];
        logic [7:0] rg[2];
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; rg[i] = '0; fd[i] = 1'b0; frx[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                fd[i] = 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0 && !(drop && i == 0 && rg[i] == 8'h15)) begin
                        fd[i]  = 1'b1;
                        frx[i] = rg[i] == 8'h12 ? ra[i] : rg[i] == 8'h13 ? rb[i] : 8'h00;
                    end
                end
                if (fs[i] === 1'b1) begin
                    cnt[i] = dly[i];
                    rg[i]  = ftx[i][15:8];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst[0]) busy = 1'b0;
            else if (fs[0] === 1'b1) begin
                nstart++;
                if (exp_q.size() > 0) chk("frame", 32'(ftx[0]), 32'(exp_q.pop_front()));
                hold = ftx[0];
                busy = 1'b1;
            end else if (busy && fd[0]) begin
                chk("tx_hold", 32'(ftx[0]), 32'(hold));
                busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_init();
        exp_q.push_back(24'h400A08);
        exp_q.push_back(24'h4200FF);
        exp_q.push_back(24'h4201FF);
        exp_q.push_back(24'h400000);
        exp_q.push_back(24'h400100);
    endtask

    task automatic push_poll(input logic [15:0] l);
        exp_q.push_back({8'h40, 8'h14, l[7:0]});
        exp_q.push_back({8'h40, 8'h15, l[15:8]});
        exp_q.push_back(24'h431200);
        exp_q.push_back(24'h431300);
    endtask

    task automatic wait_init(input int i);
        int c = 0;
        while (idn[i] !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("init_done", 32'(idn[i]), 32'd1);
    endtask

    task automatic wait_start_reg(input int i, input logic [7:0] r);
        int c = 0;
        @(negedge clk);
        while (!(fs[i] === 1'b1 && ftx[i][15:8] == r) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("frame_seen", 32'(fs[i]), 32'd1);
    endtask

    task automatic wait_dones(input int want);
        int k = 0, c = 0;
        while (k < want && c < 2000) begin
            @(negedge clk);
            c++;
            if (fd[0] === 1'b1) k++;
        end
        chk("done_count", 32'(k), 32'(want));
    endtask

    task automatic chk_rst();
        chk("rst_tx", 32'(ftx[0]), 32'd0);
        chk("rst_out", {12'd0, fs[0], idn[0], ovr[0], toe[0], sw[0]}, 32'd0);
    endtask

    initial begin
        vt[0] = '{16'hA55A, 8'h3C, 8'hC3, 16'hC33C};
        vt[1] = '{16'h0000, 8'hFF, 8'h00, 16'h00FF};
        vt[2] = '{16'hFFFF, 8'h00, 8'hFF, 16'hFF00};
        rst[0] = 1'b1; rst[1] = 1'b1;
        led[0] = vt[0].led; led[1] = 16'h0F0F;
        ra[0] = vt[0].ra; rb[0] = vt[0].rb; ra[1] = 8'h00; rb[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst[1] = 1'b0;
        wait_init(1);
        wait_start_reg(1, 8'h14);
        chk("ovr_before", 32'(ovr[1]), 32'd0);
        n = 1;
        repeat (190) begin
            @(negedge clk);
            if (fs[1] === 1'b1) n++;
        end
        chk("ovr_frames", 32'(n), 32'd4);
        chk("overrun", 32'(ovr[1]), 32'd1);
        repeat (250) @(negedge clk);
        chk("ovr_sticky", 32'(ovr[1]), 32'd1);
        @(negedge clk);
        chk_rst();
        push_init();
        @(posedge clk);
        #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("start_lat0", 32'(fs[0]), 32'd0);
        @(negedge clk);
        chk("start_lat1", 32'(fs[0]), 32'd1);
        wait_init(0);
        prev = 16'h0000;
        for (int v = 0; v < 3; v++) begin
            led[0] = vt[v].led; ra[0] = vt[v].ra; rb[0] = vt[v].rb;
            push_poll(vt[v].led);
            wait_dones(4);
            chk("sw_atomic", 32'(sw[0]), 32'(prev));
            @(negedge clk);
            chk("sw", 32'(sw[0]), 32'(vt[v].sw));
            prev = vt[v].sw;
        end
        chk("ovr_none", 32'(ovr[0]), 32'd0);
        drop = 1'b1;
        exp_q.push_back({8'h40, 8'h14, vt[2].led[7:0]});
        exp_q.push_back({8'h40, 8'h15, vt[2].led[15:8]});
        push_init();
        wait_start_reg(0, 8'h15);
        repeat (4000) @(negedge clk);
        chk("to_early", 32'(toe[0]), 32'd0);
        n = 0;
        while (toe[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_err", 32'(toe[0]), 32'd1);
        chk("to_init_done", 32'(idn[0]), 32'd0);
        chk("to_sw_hold", 32'(sw[0]), 32'(prev));
        drop = 1'b0;
        wait_init(0);
        chk("to_err_sticky", 32'(toe[0]), 32'd1);
        wait_start_reg(0, 8'h14);
        repeat (29) @(posedge clk);
        #1 rst[0] = 1'b1;
        push_init();
        @(posedge clk);
        #1 rst[0] = 1'b0;
        @(negedge clk);
        chk_rst();
        n0 = nstart;
        led[0] = 16'h1234; ra[0] = 8'h11; rb[0] = 8'h22;
        wait_init(0);
        chk("rst_init_frames", 32'(nstart - n0), 32'd5);
        push_poll(16'h1234);
        wait_start_reg(0, 8'h14);
        led[0] = 16'h5678;
        wait_dones(4);
        @(negedge clk);
        chk("sw_snap", 32'(sw[0]), 32'h2211);
        ra[0] = 8'h33; rb[0] = 8'h44;
        push_poll(16'h5678);
        wait_dones(4);
        @(negedge clk);
        chk("sw_next", 32'(sw[0]), 32'h4433);
        chk("ovr_after_rst", 32'(ovr[0]), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
